// File: rtl/uart_frame_decoder.sv
// Frame decoder behind a UART receiver: SOF, LEN, LEN payload bytes, XOR CHK -> valid/ready byte stream.
// Latency: first payload byte is valid the cycle after the good CHK strobe; then one byte per accepting clock.
// Backpressure: output is held while ready is low; bytes arriving during output are dropped and flagged.
module uart_frame_decoder #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter int         TIMEOUT_CLKS = 4160
) (
    input  logic       ip_Clock,
    input  logic       ip_Rst_n,
    input  logic       ip_Rx_DV,
    input  logic [7:0] ip_Rx_Byte,
    output logic       op_Out_Valid,
    input  logic       ip_Out_Ready,
    output logic [7:0] op_Out_Byte,
    output logic       op_Out_Last,
    output logic [7:0] op_Frame_Len,
    output logic       op_Busy,
    output logic       op_Err_Chk,
    output logic       op_Err_Len,
    output logic       op_Err_Timeout,
    output logic       op_Overrun
);
    localparam int          IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]  LP_MAX      = 8'(MAX_LEN);
    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_OUTPUT} state_t;

    state_t      r_state, w_next_state;
    logic [7:0]  r_buf [MAX_LEN];
    logic [7:0]  r_len, r_chk, r_idx, r_rd_idx;
    logic [15:0] r_tmo;
    logic        r_out_valid, r_out_last, r_busy;
    logic [7:0]  r_out_byte, r_frame_len;
    logic        r_err_chk, r_err_len, r_err_tmo, r_overrun;

    logic        w_err_chk, w_err_len, w_err_tmo;
    logic        w_len_ok, w_tmo_hit, w_tmo_run, w_accept, w_rd_is_last;
    logic [7:0]  w_rd_nxt;

    assign w_len_ok     = (ip_Rx_Byte != 8'd0) && (ip_Rx_Byte <= LP_MAX);
    assign w_tmo_hit    = (r_tmo == LP_TMO_LAST) && !ip_Rx_DV;
    assign w_tmo_run    = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    assign w_accept     = r_out_valid && ip_Out_Ready;
    assign w_rd_nxt     = r_rd_idx + 8'd1;
    assign w_rd_is_last = (r_rd_idx == r_len - 8'd1);

    always_comb begin
        w_next_state = r_state;
        w_err_chk    = 1'b0;
        w_err_len    = 1'b0;
        w_err_tmo    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ip_Rx_DV && (ip_Rx_Byte == SOF_BYTE)) w_next_state = S_LEN;
            end
            S_LEN: begin
                if (ip_Rx_DV) begin
                    if (w_len_ok) begin
                        w_next_state = S_PAYLOAD;
                    end else begin
                        w_err_len    = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (ip_Rx_DV) begin
                    if (r_idx == r_len - 8'd1) w_next_state = S_CHK;
                end else if (w_tmo_hit) begin
                    w_err_tmo    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_CHK: begin
                if (ip_Rx_DV) begin
                    if (ip_Rx_Byte == r_chk) begin
                        w_next_state = S_OUTPUT;
                    end else begin
                        w_err_chk    = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end else if (w_tmo_hit) begin
                    w_err_tmo    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (w_accept && w_rd_is_last) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Payload storage carries no reset: contents are only read after being written.
    always_ff @(posedge ip_Clock) begin
        if ((r_state == S_PAYLOAD) && ip_Rx_DV) r_buf[r_idx[IW-1:0]] <= ip_Rx_Byte;
    end

    always_ff @(posedge ip_Clock or negedge ip_Rst_n) begin
        if (!ip_Rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_chk       <= '0;
            r_idx       <= '0;
            r_rd_idx    <= '0;
            r_tmo       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_byte  <= '0;
            r_frame_len <= '0;
            r_busy      <= 1'b0;
            r_err_chk   <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_tmo   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= (w_next_state != S_IDLE);
            r_err_chk <= w_err_chk;
            r_err_len <= w_err_len;
            r_err_tmo <= w_err_tmo;
            r_overrun <= (r_state == S_OUTPUT) && ip_Rx_DV;

            if (ip_Rx_DV || w_err_tmo || !w_tmo_run) r_tmo <= '0;
            else                                     r_tmo <= r_tmo + 16'd1;

            case (r_state)
                S_LEN: begin
                    if (ip_Rx_DV && w_len_ok) begin
                        r_len <= ip_Rx_Byte;
                        r_chk <= ip_Rx_Byte;
                        r_idx <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (ip_Rx_DV) begin
                        r_chk <= r_chk ^ ip_Rx_Byte;
                        r_idx <= r_idx + 8'd1;
                    end
                end
                S_CHK: begin
                    if (ip_Rx_DV && (ip_Rx_Byte == r_chk)) begin
                        r_out_valid <= 1'b1;
                        r_out_byte  <= r_buf[0];
                        r_out_last  <= (r_len == 8'd1);
                        r_frame_len <= r_len;
                        r_rd_idx    <= '0;
                    end
                end
                S_OUTPUT: begin
                    // Next byte is loaded on the accepting edge so the stream has no bubbles.
                    if (w_accept) begin
                        if (w_rd_is_last) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_frame_len <= '0;
                            r_rd_idx    <= '0;
                        end else begin
                            r_rd_idx   <= w_rd_nxt;
                            r_out_byte <= r_buf[w_rd_nxt[IW-1:0]];
                            r_out_last <= (w_rd_nxt == r_len - 8'd1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign op_Out_Valid   = r_out_valid;
    assign op_Out_Byte    = r_out_byte;
    assign op_Out_Last    = r_out_last;
    assign op_Frame_Len   = r_frame_len;
    assign op_Busy        = r_busy;
    assign op_Err_Chk     = r_err_chk;
    assign op_Err_Len     = r_err_len;
    assign op_Err_Timeout = r_err_tmo;
    assign op_Overrun     = r_overrun;
endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder with a frame-level reference model compared every cycle.
module tb_uart_frame_decoder;
    localparam int T = 4160;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic       rdy = 1'b1;
    logic [7:0] rxb = 8'h00;
    logic       o_vld, o_last, o_busy, o_echk, o_elen, o_etmo, o_ovr;
    logic [7:0] o_byte, o_len;

    uart_frame_decoder dut (
        .ip_Clock       (clk),
        .ip_Rst_n       (rst_n),
        .ip_Rx_DV       (dv),
        .ip_Rx_Byte     (rxb),
        .op_Out_Valid   (o_vld),
        .ip_Out_Ready   (rdy),
        .op_Out_Byte    (o_byte),
        .op_Out_Last    (o_last),
        .op_Frame_Len   (o_len),
        .op_Busy        (o_busy),
        .op_Err_Chk     (o_echk),
        .op_Err_Len     (o_elen),
        .op_Err_Timeout (o_etmo),
        .op_Overrun     (o_ovr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: parses whole bytes and holds a queue of payload bytes still owed to the consumer.
    int         m_phase;
    int         m_sil;
    logic [7:0] m_len, m_flen, m_x;
    logic [7:0] m_pay[$];
    logic [7:0] m_outq[$];
    logic       m_echk, m_elen, m_etmo, m_eovr, m_act;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_sil = 0; m_len = 0; m_flen = 0;
            m_pay.delete(); m_outq.delete();
            m_echk = 0; m_elen = 0; m_etmo = 0; m_eovr = 0;
        end else begin
            m_act = (m_outq.size() > 0);
            m_echk = 0; m_elen = 0; m_etmo = 0; m_eovr = 0;
            if (dv) begin
                m_sil = 0;
                if (m_act) m_eovr = 1;
                else case (m_phase)
                    0: if (rxb == 8'hA5) m_phase = 1;
                    1: begin
                        if (rxb >= 1 && rxb <= 16) begin
                            m_len = rxb; m_pay.delete(); m_phase = 2;
                        end else begin
                            m_elen = 1; m_phase = 0;
                        end
                    end
                    2: begin
                        m_pay.push_back(rxb);
                        if (m_pay.size() == int'(m_len)) m_phase = 3;
                    end
                    default: begin
                        m_x = m_len;
                        foreach (m_pay[i]) m_x ^= m_pay[i];
                        if (rxb == m_x) begin
                            m_outq = m_pay; m_flen = m_len;
                        end else m_echk = 1;
                        m_phase = 0;
                    end
                endcase
            end else if (m_phase != 0) begin
                m_sil++;
                if (m_sil == T) begin m_etmo = 1; m_phase = 0; m_sil = 0; end
            end
            if (m_act && rdy) void'(m_outq.pop_front());
        end
    end

    int         n_echk, n_elen, n_etmo, n_ovr, n_vseen, tmo_cyc, last_dv;
    logic [8:0] acc_q[$];
    int         acc_cyc[$];
    logic       c_ev;

    always @(negedge clk) begin
        c_ev = (m_outq.size() > 0);
        chk("valid", o_vld, c_ev);
        chk("busy", o_busy, (m_phase != 0) || c_ev);
        chk("last", o_last, m_outq.size() == 1);
        if (c_ev) begin
            chk("byte", o_byte, m_outq[0]);
            chk("frame_len", o_len, m_flen);
        end
        chk("err_chk", o_echk, m_echk);
        chk("err_len", o_elen, m_elen);
        chk("err_timeout", o_etmo, m_etmo);
        chk("overrun", o_ovr, m_eovr);
        if (o_echk) n_echk++;
        if (o_elen) n_elen++;
        if (o_etmo) begin n_etmo++; tmo_cyc = cyc; end
        if (o_ovr) n_ovr++;
        if (o_vld) n_vseen++;
        if (o_vld && rdy) begin acc_q.push_back({o_last, o_byte}); acc_cyc.push_back(cyc); end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b);
        dv = 1'b1; rxb = b;
        tick();
        last_dv = cyc;
        dv = 1'b0;
    endtask

    task automatic send_frame1();
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    endtask

    task automatic clear();
        n_echk = 0; n_elen = 0; n_etmo = 0; n_ovr = 0; n_vseen = 0;
        acc_q.delete(); acc_cyc.delete();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!o_busy && !o_vld) begin
                repeat (2) tick();
                return;
            end
            tick();
        end
        chk("drain_timeout", 1, 0);
    endtask

    task automatic chk_frame1(input string nm);
        chk({nm, "_count"}, acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk({nm, "_b0"}, acc_q[0], 9'h011);
            chk({nm, "_b1"}, acc_q[1], 9'h022);
            chk({nm, "_b2"}, acc_q[2], 9'h133);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        chk("rst_valid", o_vld, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_byte", o_byte, 0);
        chk("rst_errs", {o_echk, o_elen, o_etmo, o_ovr}, 0);
        tick(); rst_n = 1'b1; tick();

        // 1: good 3-byte frame, ready high, CHK = 03^11^22^33 = 03
        clear();
        send_frame1();
        drain(50);
        chk_frame1("t1");
        if (acc_cyc.size() == 3) begin
            chk("t1_first_lat", acc_cyc[0] - last_dv, 0);
            chk("t1_gap01", acc_cyc[1] - acc_cyc[0], 1);
            chk("t1_gap12", acc_cyc[2] - acc_cyc[1], 1);
        end
        chk("t1_errs", n_echk + n_elen + n_etmo + n_ovr, 0);

        // 2: bad checksum (expected 32)
        clear();
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'hFF);
        drain(50);
        chk("t2_err_chk", n_echk, 1);
        chk("t2_valid_seen", n_vseen, 0);
        chk("t2_idle", o_busy, 0);

        // 3: zero and oversize LEN, then a 1-byte frame
        clear();
        send(8'hA5); send(8'h00);
        send(8'hA5); send(8'h11);
        send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
        drain(50);
        chk("t3_err_len", n_elen, 2);
        chk("t3_count", acc_q.size(), 1);
        if (acc_q.size() == 1) chk("t3_b0", acc_q[0], 9'h15A);

        // 4: backpressure and an overrun byte during output
        clear();
        rdy = 1'b0;
        send_frame1();
        repeat (5) tick();
        chk("t4_hold_vld", o_vld, 1);
        chk("t4_hold_byte", o_byte, 8'h11);
        chk("t4_hold_len", o_len, 8'h03);
        for (int i = 0; i < 10; i++) begin
            rdy = ~rdy;
            if (i == 2) send(8'h77);
            else tick();
        end
        rdy = 1'b1;
        drain(50);
        chk_frame1("t4");
        chk("t4_overrun", n_ovr, 1);

        // 5: noise ignored, then a stalled frame times out
        clear();
        send(8'h00); send(8'hFF);
        tick();
        chk("t5_noise_idle", o_busy, 0);
        send(8'hA5); send(8'h02); send(8'h10);
        for (int i = 0; i < T + 200 && n_etmo == 0; i++) tick();
        chk("t5_tmo_count", n_etmo, 1);
        chk("t5_tmo_delay", tmo_cyc - last_dv, 4160);
        chk("t5_other_errs", n_echk + n_elen, 0);
        drain(50);
        clear();
        send_frame1();
        drain(50);
        chk_frame1("t5_after");

        // 6: reset mid-payload and mid-output
        clear();
        send(8'hA5); send(8'h03); send(8'h11);
        #2 rst_n = 1'b0;
        #1;
        chk("t6a_busy", o_busy, 0);
        chk("t6a_valid", o_vld, 0);
        tick(); rst_n = 1'b1; tick();
        rdy = 1'b0;
        send_frame1();
        tick();
        chk("t6b_valid_pre", o_vld, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6b_valid", o_vld, 0);
        chk("t6b_byte", o_byte, 0);
        chk("t6b_len", o_len, 0);
        chk("t6b_last", o_last, 0);
        chk("t6b_busy", o_busy, 0);
        tick(); rst_n = 1'b1; rdy = 1'b1; tick();
        clear();
        send_frame1();
        drain(50);
        chk_frame1("t6_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
